// File: rtl/mult_scheduler_pkg.sv
// mult_scheduler_pkg: FSM states and channel priority helper shared by the multiplier scheduler
package mult_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, MUL, STORE, COMMIT} state_t;
  function automatic logic [3:0] lowest_set(input logic [7:0] m);
    lowest_set = 4'd0;
    for (int i = 7; i >= 0; i--)
      if (m[i]) lowest_set = {1'b1, 3'(i)};
  endfunction
endpackage

// File: rtl/mult_scheduler_serial_mult.sv
// mult_scheduler_serial_mult: radix-2 signed shift-add multiplier, B cycles, product valid on the last cycle
module mult_scheduler_serial_mult #(
  parameter int B = 16
) (
  input  logic           bclk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [B-1:0]   a,
  input  logic [B-1:0]   b,
  output logic [2*B-1:0] p,
  output logic           valid
);
  localparam int W = 2 * B;
  localparam int CW = $clog2(B);
  logic          run;
  logic [CW-1:0] cnt, idx;
  logic [W-1:0]  a_sh, a_cur, acc, part;
  logic [B-1:0]  b_sh, b_cur;
  // start restarts unconditionally so an aborted product never blocks the next one
  always_comb begin
    idx = start ? '0 : cnt;
    a_cur = start ? {{B{a[B-1]}}, a} : a_sh;
    b_cur = start ? b : b_sh;
    part = !b_cur[0] ? '0 : (idx == CW'(B-1)) ? -a_cur : a_cur;
    p = (start ? '0 : acc) + part;
    valid = (start | run) && idx == CW'(B-1);
  end
  always_ff @(posedge bclk or negedge reset_n)
    if (!reset_n) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
      a_sh <= '0;
      b_sh <= '0;
    end else if (start | run) begin
      acc <= p;
      a_sh <= a_cur << 1;
      b_sh <= b_cur >> 1;
      cnt <= idx + 1'b1;
      run <= ~valid;
    end
endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: time-shares one serial Q1.(BITSIZE-1) multiplier across NCH operand pairs per audio frame
module mult_scheduler
  import mult_scheduler_pkg::*;
#(
  parameter int BITSIZE = 16,
  parameter int NCH = 2
) (
  input  logic                   bclk,
  input  logic                   reset_n,
  input  logic                   lrclk,
  input  logic [NCH-1:0]         enable,
  input  logic [NCH*BITSIZE-1:0] in1,
  input  logic [NCH*BITSIZE-1:0] in2,
  output logic [NCH*BITSIZE-1:0] out,
  output logic                   done,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   clr_ovr
);
  localparam int B = BITSIZE;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [B-1:0] QMAX = {1'b0, {(B-1){1'b1}}};
  localparam logic [2*B-1:0] PSAT = {2'b01, {(2*B-2){1'b0}}};
  state_t         state, nxt;
  logic           lr_d1, lr_d2, fs, first, m_valid;
  logic [NCH-1:0] en_r;
  logic [B-1:0]   op_a [NCH];
  logic [B-1:0]   op_b [NCH];
  logic [B-1:0]   shadow [NCH];
  logic [B-1:0]   prod_r, scaled;
  logic [CW-1:0]  ch;
  logic [3:0]     lo_in, lo_next;
  logic [2*B-1:0] m_p;
  assign fs = lr_d1 & ~lr_d2;
  assign done = state == COMMIT;
  assign busy = state != IDLE;
  assign lo_in = lowest_set(8'(enable));
  assign lo_next = lowest_set(8'(en_r) & ~((8'd2 << ch) - 8'd1));
  // (-1)*(-1) is the only product that leaves the Q range
  assign scaled = (m_p == PSAT) ? QMAX : m_p[2*B-2 -: B];
  mult_scheduler_serial_mult #(.B(B)) u_mult (
    .bclk    (bclk),
    .reset_n (reset_n),
    .start   (first),
    .a       (op_a[ch]),
    .b       (op_b[ch]),
    .p       (m_p),
    .valid   (m_valid)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = IDLE;
      LOAD:    nxt = lo_in[3] ? MUL : COMMIT;
      MUL:     nxt = m_valid ? STORE : MUL;
      STORE:   nxt = lo_next[3] ? MUL : COMMIT;
      COMMIT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (fs) nxt = LOAD;
  end
  always_ff @(posedge bclk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      lr_d1 <= 1'b0;
      lr_d2 <= 1'b0;
      first <= 1'b0;
      en_r <= '0;
      ch <= '0;
      prod_r <= '0;
      overrun <= 1'b0;
      out <= '0;
      for (int k = 0; k < NCH; k++) begin
        op_a[k] <= '0;
        op_b[k] <= '0;
        shadow[k] <= '0;
      end
    end else begin
      state <= nxt;
      lr_d1 <= lrclk;
      lr_d2 <= lr_d1;
      first <= nxt == MUL && state != MUL;
      overrun <= clr_ovr ? 1'b0 : (fs && busy && state != COMMIT) ? 1'b1 : overrun;
      if (state == LOAD) begin
        en_r <= enable;
        ch <= CW'(lo_in[2:0]);
        for (int k = 0; k < NCH; k++) begin
          op_a[k] <= in1[k*B +: B];
          op_b[k] <= in2[k*B +: B];
        end
      end
      if (state == MUL && m_valid) prod_r <= scaled;
      if (state == STORE) begin
        shadow[ch] <= prod_r;
        ch <= CW'(lo_next[2:0]);
      end
      if (state == COMMIT)
        for (int k = 0; k < NCH; k++)
          if (en_r[k]) out[k*B +: B] <= shadow[k];
    end
endmodule

// File: tb/tb_mult_scheduler.sv
// tb_mult_scheduler: directed and randomized frames checked against an arithmetic Q-format model
module tb_mult_scheduler;
  localparam int B = 16;
  localparam int N = 2;
  logic bclk = 1'b0, reset_n = 1'b1, lrclk = 1'b0, clr_ovr = 1'b0;
  logic [N-1:0] enable = '0;
  logic [N*B-1:0] in1 = '0, in2 = '0;
  logic [N*B-1:0] out;
  logic done, busy, overrun;
  int total = 0, bad = 0;
  int n_en, dat, dcnt;
  logic [15:0] exp_out [N];
  logic [15:0] exp_nxt [N];

  always #5 bclk = ~bclk;

  mult_scheduler #(.BITSIZE(B), .NCH(N)) dut (
    .bclk    (bclk),
    .reset_n (reset_n),
    .lrclk   (lrclk),
    .enable  (enable),
    .in1     (in1),
    .in2     (in2),
    .out     (out),
    .done    (done),
    .busy    (busy),
    .overrun (overrun),
    .clr_ovr (clr_ovr)
  );

  function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
    longint p, r;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p >>> 15;
    if (r > 32767) r = 32767;
    return r[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outs(input string tag);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s out%0d", tag, k), 32'(out[k*B +: B]), 32'(exp_out[k]));
  endtask

  task automatic drive(input logic [1:0] en, input logic [15:0] a0, b0, a1, b1);
    enable = en;
    in1 = {a1, a0};
    in2 = {b1, b0};
  endtask

  task automatic prep();
    n_en = 0;
    for (int k = 0; k < N; k++) begin
      if (enable[k]) begin
        n_en++;
        exp_nxt[k] = qmul(in1[k*B +: B], in2[k*B +: B]);
      end else exp_nxt[k] = exp_out[k];
    end
  endtask

  task automatic tick();
    @(posedge bclk);
    #1;
  endtask

  // one 64-cycle frame; cycle 0 is the cycle in which the frame start is seen
  task automatic frame(input bit scramble, output int d_at, output int d_cnt);
    lrclk = 1'b1;
    d_at = -1;
    d_cnt = 0;
    for (int c = 0; c < 64; c++) begin
      tick();
      if (c == 32) lrclk = 1'b0;
      if (done) begin
        d_cnt++;
        if (d_at < 0) d_at = c;
      end
      if (scramble && c == 4) begin
        in1 = $urandom;
        in2 = $urandom;
        enable = 2'($urandom);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) exp_out[k] = '0;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    chk("reset out", out, 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();
    // T1
    drive(2'b11, 16'h4000, 16'h4000, 16'hC000, 16'h4000);
    prep();
    frame(1'b1, dat, dcnt);
    chk("T1 latency", 32'(dat), 32'd36);
    chk("T1 done count", 32'(dcnt), 32'd1);
    chk("T1 out0", 32'(out[15:0]), 32'h2000);
    chk("T1 out1", 32'(out[31:16]), 32'hE000);
    exp_out = exp_nxt;
    // T2
    drive(2'b11, 16'h8000, 16'h8000, 16'hFFFF, 16'h7FFF);
    prep();
    frame(1'b1, dat, dcnt);
    chk("T2 out0 sat", 32'(out[15:0]), 32'h7FFF);
    chk("T2 out1 floor", 32'(out[31:16]), 32'hFFFF);
    exp_out = exp_nxt;
    check_outs("T2 model");
    // T3
    drive(2'b10, 16'h1111, 16'h2222, 16'h2000, 16'h6000);
    prep();
    frame(1'b1, dat, dcnt);
    chk("T3 latency n1", 32'(dat), 32'd19);
    chk("T3 out0 hold", 32'(out[15:0]), 32'h7FFF);
    chk("T3 out1", 32'(out[31:16]), 32'h1800);
    exp_out = exp_nxt;
    drive(2'b00, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    prep();
    frame(1'b0, dat, dcnt);
    chk("T3 latency n0", 32'(dat), 32'd2);
    chk("T3 done count n0", 32'(dcnt), 32'd1);
    check_outs("T3 none");
    // T4: second frame start 10 cycles into MUL
    drive(2'b11, 16'h0100, 16'h0100, 16'h0200, 16'h0200);
    lrclk = 1'b1;
    dat = -1;
    dcnt = 0;
    for (int c = 0; c < 64; c++) begin
      tick();
      if (c == 2) lrclk = 1'b0;
      if (c == 5) begin
        drive(2'b11, 16'h1234, 16'h4000, 16'h8000, 16'h4000);
        prep();
      end
      if (c == 11) lrclk = 1'b1;
      if (c == 30) lrclk = 1'b0;
      if (done) begin
        dcnt++;
        if (dat < 0) dat = c;
      end
      if (c == 12) chk("T4 overrun before", 32'(overrun), 32'd0);
      if (c == 13) chk("T4 overrun set", 32'(overrun), 32'd1);
      if (c == 47) check_outs("T4 hold");
    end
    chk("T4 latency", 32'(dat), 32'd48);
    chk("T4 done count", 32'(dcnt), 32'd1);
    exp_out = exp_nxt;
    check_outs("T4 restart");
    chk("T4 overrun sticky", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("T4 overrun clear", 32'(overrun), 32'd0);
    // T5: reset during STORE of ch0
    drive(2'b11, 16'h4000, 16'h4000, 16'h4000, 16'h4000);
    lrclk = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      tick();
      if (c == 2) lrclk = 1'b0;
    end
    chk("T5 busy in store", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("T5 out", out, 32'd0);
    chk("T5 busy", 32'(busy), 32'd0);
    chk("T5 done", 32'(done), 32'd0);
    for (int k = 0; k < N; k++) exp_out[k] = '0;
    tick();
    reset_n = 1'b1;
    tick();
    drive(2'b11, 16'h7FFF, 16'h7FFF, 16'h8001, 16'h0003);
    prep();
    frame(1'b1, dat, dcnt);
    chk("T5 latency", 32'(dat), 32'd36);
    exp_out = exp_nxt;
    check_outs("T5 after");
    // T6: randomized frames
    for (int f = 0; f < 1000; f++) begin
      drive(2'($urandom),
            ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom),
            ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom),
            ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom),
            ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom));
      prep();
      frame(1'b1, dat, dcnt);
      chk($sformatf("T6 f%0d latency", f), 32'(dat), 32'(2 + n_en * 17));
      chk($sformatf("T6 f%0d done count", f), 32'(dcnt), 32'd1);
      exp_out = exp_nxt;
      check_outs($sformatf("T6 f%0d", f));
      chk($sformatf("T6 f%0d overrun", f), 32'(overrun), 32'd0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
